// File: rtl/hamming_syndrome_unit_pkg.sv
// Shared types and constants for the Hamming decode datapath.
// The parity-group helper is shared by the syndrome calculator and by the encoder.
package hamming_pkg;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_SINGLE = 2'b01,
    ERR_DOUBLE = 2'b10
  } err_e;

  typedef enum logic [2:0] {
    StIdle,
    StFetchL,
    StFetchH,
    StCaptH,
    StEmit,
    StDone
  } state_e;

  localparam int unsigned P1_POS = 1;
  localparam int unsigned P2_POS = 2;
  localparam int unsigned P4_POS = 4;
  localparam int unsigned P8_POS = 8;

  // XOR of every codeword bit whose position index has a bit in common with pos.
  function automatic logic parity_group(input logic [15:0] w, input int unsigned pos);
    logic p;
    p = 1'b0;
    for (int unsigned k = 1; k < 16; k++) begin
      if ((k & pos) != 0) p ^= w[k];
    end
    return p;
  endfunction

endpackage

// File: rtl/hamming_syndrome_unit_if.sv
// Memory-read and syndrome-output bus of the syndrome unit.
// master = syndrome unit side, slave = memory / LUT side.
interface hamming_syndrome_unit_if #(
  parameter int unsigned AW = 8
);
  import hamming_pkg::*;

  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [7:0]    mem_rdata;
  logic          syn_valid;
  logic          syn_ready;
  logic [7:0]    syn_out;
  err_e          err_code;
  logic [15:0]   code_word;
  logic [3:0]    word_idx;

  modport master (
    output mem_addr, mem_rd_en, syn_valid, syn_out, err_code, code_word, word_idx,
    input  mem_rdata, syn_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, syn_valid, syn_out, err_code, code_word, word_idx,
    output mem_rdata, syn_ready
  );

endinterface

// File: rtl/hamming_syndrome_calc.sv
// Combinational syndrome, overall parity and error class for one 16-bit codeword.
// Position k of the codeword is word[k]; position 0 holds the overall parity bit.
module hamming_syndrome_calc
  import hamming_pkg::*;
(
  input  logic [15:0] word,
  output logic [3:0]  syndrome,
  output logic        overall,
  output err_e        err
);

  always_comb begin
    syndrome = {parity_group(word, P8_POS), parity_group(word, P4_POS),
                parity_group(word, P2_POS), parity_group(word, P1_POS)};
    overall  = ^word;
    // Odd overall parity is always a single flip, even when it hit p0 (syndrome 0).
    if (overall) begin
      err = ERR_SINGLE;
    end else if (syndrome != 4'd0) begin
      err = ERR_DOUBLE;
    end else begin
      err = ERR_NONE;
    end
  end

endmodule

// File: rtl/hamming_syndrome_unit.sv
// Walks NUM_WORDS stored codewords (LSW, MSW byte pairs), emitting one syndrome per word
// over a valid/ready handshake. All outputs are registered.
module hamming_syndrome_unit
  import hamming_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 15,
  parameter int unsigned SRC_BASE  = 30,
  parameter int unsigned AW        = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  hamming_syndrome_unit_if.master bus
);

  state_e      state_q;
  logic [3:0]  idx_q;
  logic [7:0]  lsw_q;

  logic [3:0]  calc_syndrome;
  logic        calc_overall;
  err_e        calc_err;

  hamming_syndrome_calc u_calc (
    .word     ({bus.mem_rdata, lsw_q}),
    .syndrome (calc_syndrome),
    .overall  (calc_overall),
    .err      (calc_err)
  );

  // Address arithmetic wraps modulo 2^AW.
  function automatic logic [AW-1:0] lsw_addr(input logic [3:0] i);
    return AW'(SRC_BASE + 2 * int'(i));
  endfunction

  assign bus.word_idx = idx_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      lsw_q         <= '0;
      bus.mem_addr  <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.syn_valid <= 1'b0;
      bus.syn_out   <= '0;
      bus.err_code  <= ERR_NONE;
      bus.code_word <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q       <= StFetchL;
            idx_q         <= '0;
            busy          <= 1'b1;
            bus.mem_addr  <= lsw_addr(4'd0);
            bus.mem_rd_en <= 1'b1;
          end
        end
        StFetchL: begin
          state_q      <= StFetchH;
          bus.mem_addr <= lsw_addr(idx_q) + AW'(1);
        end
        StFetchH: begin
          state_q       <= StCaptH;
          lsw_q         <= bus.mem_rdata;
          bus.mem_addr  <= '0;
          bus.mem_rd_en <= 1'b0;
        end
        StCaptH: begin
          state_q       <= StEmit;
          bus.syn_out   <= {4'b0000, calc_syndrome};
          bus.err_code  <= calc_overall ? ERR_SINGLE : calc_err;
          bus.code_word <= {bus.mem_rdata, lsw_q};
          bus.syn_valid <= 1'b1;
        end
        StEmit: begin
          if (bus.syn_ready) begin
            bus.syn_valid <= 1'b0;
            if (idx_q == 4'(NUM_WORDS - 1)) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q       <= StFetchL;
              idx_q         <= idx_q + 4'd1;
              bus.mem_addr  <= lsw_addr(idx_q + 4'd1);
              bus.mem_rd_en <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_syndrome_unit.sv
// Scoreboard bench for hamming_syndrome_unit: directed codewords with hand-computed syndromes.
module tb_hamming_syndrome_unit;
  import hamming_pkg::*;

  localparam int unsigned NW   = 15;
  localparam int unsigned BASE = 30;

  typedef struct packed {
    logic [3:0]  idx;
    logic [7:0]  syn;
    logic [1:0]  err;
    logic [15:0] cw;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  hamming_syndrome_unit_if #(.AW(8)) bus ();

  hamming_syndrome_unit #(.NUM_WORDS(NW), .SRC_BASE(BASE), .AW(8)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [256];
  int          rd_cnt [256];
  logic [15:0] cw_tab  [NW];
  logic [7:0]  syn_tab [NW];
  logic [1:0]  err_tab [NW];
  exp_t        sb [$];
  int          done_seen;
  bit          rand_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous-read data memory with per-address read counters.
  always @(posedge Clk) begin
    if (bus.mem_rd_en) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      rd_cnt[bus.mem_addr] = rd_cnt[bus.mem_addr] + 1;
    end
  end

  initial begin
    bus.syn_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      bus.syn_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each transfer and checks stall stability.
  logic        stalled = 1'b0;
  logic [29:0] held;
  always @(negedge Clk) begin
    if (!Reset) begin
      if (done) done_seen++;
      if (stalled) begin
        chk("valid_hold", 32'(bus.syn_valid), 32'd1);
        chk("stall_stable", 32'({bus.syn_out, bus.err_code, bus.code_word, bus.word_idx}),
            32'(held));
      end
      stalled = bus.syn_valid && !bus.syn_ready;
      held    = {bus.syn_out, bus.err_code, bus.code_word, bus.word_idx};
      if (bus.syn_valid && bus.syn_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_transfer", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("word_idx", 32'(bus.word_idx), 32'(e.idx));
          chk("syn_out", 32'(bus.syn_out), 32'(e.syn));
          chk("err_code", 32'(bus.err_code), 32'(e.err));
          chk("code_word", 32'(bus.code_word), 32'(e.cw));
        end
      end
      if (!bus.mem_rd_en) chk("idle_addr", 32'(bus.mem_addr), 32'd0);
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic check_zero(input string nm);
    chk(nm, 32'({bus.mem_addr, bus.mem_rd_en, bus.syn_valid, bus.syn_out, bus.err_code}), 32'd0);
    chk({nm, "_cw"}, 32'({bus.code_word, bus.word_idx, busy, done}), 32'd0);
  endtask

  // Issue start, load the scoreboard and check first address and start-to-valid latency.
  task automatic run_start();
    int cyc;
    for (int a = 0; a < 256; a++) rd_cnt[a] = 0;
    done_seen = 0;
    for (int i = 0; i < int'(NW); i++) sb.push_back({4'(i), syn_tab[i], err_tab[i], cw_tab[i]});
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    chk("first_addr", 32'({bus.mem_rd_en, bus.mem_addr}), 32'({1'b1, 8'(BASE)}));
    chk("first_idx", 32'(bus.word_idx), 32'd0);
    cyc = 1;
    while (!bus.syn_valid && cyc < 20) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd4);
  endtask

  task automatic wait_done_and_check();
    int cyc;
    cyc = 0;
    while (busy && cyc < 2000) begin
      @(posedge Clk);
      #1;
      cyc++;
    end
    chk("finished_in_budget", 32'(busy), 32'd0);
    @(posedge Clk);
    #1;
    chk("done_pulses", 32'(done_seen), 32'd1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    for (int a = 0; a < 256; a++) begin
      if (a >= int'(BASE) && a < int'(BASE + 2 * NW)) chk("read_once", 32'(rd_cnt[a]), 32'd1);
      else if (rd_cnt[a] != 0) chk("stray_read", 32'(rd_cnt[a]), 32'd0);
    end
  endtask

  initial begin
    // {MSW,LSW}, expected syndrome, expected class (hand-derived).
    cw_tab[0]  = 16'h0000; syn_tab[0]  = 8'h00; err_tab[0]  = 2'b00;
    cw_tab[1]  = 16'h0008; syn_tab[1]  = 8'h03; err_tab[1]  = 2'b01;
    cw_tab[2]  = 16'h0018; syn_tab[2]  = 8'h07; err_tab[2]  = 2'b10;
    cw_tab[3]  = 16'h0001; syn_tab[3]  = 8'h00; err_tab[3]  = 2'b01;
    cw_tab[4]  = 16'hFFFF; syn_tab[4]  = 8'h00; err_tab[4]  = 2'b00;
    cw_tab[5]  = 16'h0002; syn_tab[5]  = 8'h01; err_tab[5]  = 2'b01;
    cw_tab[6]  = 16'h0100; syn_tab[6]  = 8'h08; err_tab[6]  = 2'b01;
    cw_tab[7]  = 16'h8000; syn_tab[7]  = 8'h0F; err_tab[7]  = 2'b01;
    cw_tab[8]  = 16'h0006; syn_tab[8]  = 8'h03; err_tab[8]  = 2'b10;
    cw_tab[9]  = 16'h0003; syn_tab[9]  = 8'h01; err_tab[9]  = 2'b10;
    cw_tab[10] = 16'h8001; syn_tab[10] = 8'h0F; err_tab[10] = 2'b10;
    cw_tab[11] = 16'h000F; syn_tab[11] = 8'h00; err_tab[11] = 2'b00;
    cw_tab[12] = 16'h0110; syn_tab[12] = 8'h0C; err_tab[12] = 2'b10;
    cw_tab[13] = 16'hC000; syn_tab[13] = 8'h01; err_tab[13] = 2'b10;
    cw_tab[14] = 16'h0111; syn_tab[14] = 8'h0C; err_tab[14] = 2'b01;
    for (int a = 0; a < 256; a++) mem[a] = 8'hA5;
    for (int i = 0; i < int'(NW); i++) begin
      mem[BASE + 2 * i]     = cw_tab[i][7:0];
      mem[BASE + 2 * i + 1] = cw_tab[i][15:8];
    end

    repeat (3) @(posedge Clk);
    #1;
    check_zero("reset_state");
    Reset = 1'b0;
    @(posedge Clk);
    #1;

    // Full block, ready held high; a stray start mid-run must be ignored.
    run_start();
    repeat (7) @(posedge Clk);
    #1;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    wait_done_and_check();

    // Full block with random backpressure, plus another start while busy.
    rand_ready = 1'b1;
    run_start();
    repeat (13) @(posedge Clk);
    #1;
    start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    wait_done_and_check();

    // Reset during FETCH_H of word 5, then a clean restart.
    rand_ready = 1'b0;
    run_start();
    begin
      int cyc;
      cyc = 0;
      while (!(bus.mem_rd_en && bus.mem_addr == 8'(BASE + 11)) && cyc < 200) begin
        @(posedge Clk);
        #1;
        cyc++;
      end
      chk("reached_word5", 32'(bus.word_idx), 32'd5);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    sb.delete();
    check_zero("mid_reset");
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    rand_ready = 1'b1;
    run_start();
    wait_done_and_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
